// File: rtl/sap_pkg.sv
// Shared types for the SAP-1 control sequencer: opcodes, T-state indices
// and the packed control word the sequencer decodes into.
package sap_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_LDA = 4'd1,
    OP_ADD = 4'd2,
    OP_SUB = 4'd3,
    OP_STA = 4'd4,
    OP_LDI = 4'd5,
    OP_JMP = 4'd6,
    OP_JC  = 4'd7,
    OP_JZ  = 4'd8,
    OP_OUT = 4'd14,
    OP_HLT = 4'd15
  } opcode_e;

  // Bit positions of each T-state in the one-hot ring
  localparam int T1 = 0;
  localparam int T2 = 1;
  localparam int T3 = 2;
  localparam int T4 = 3;
  localparam int T5 = 4;
  localparam int T6 = 5;

  typedef struct packed {
    logic pc_oe;
    logic pc_inc;
    logic pc_load;
    logic mar_load;
    logic ram_oe;
    logic ram_we;
    logic ir_load;
    logic ir_oe;
    logic a_load;
    logic a_oe;
    logic b_load;
    logic alu_oe;
    logic alu_sub;
    logic flags_load;
    logic out_load;
  } ctrl_word_t;

endpackage

// File: rtl/sap_ring_counter.sv
// One-hot T-state ring: synchronous active-low reset, advance enable and a
// synchronous restart that sends the ring back to its first state.
module sap_ring_counter #(
  parameter int NT = 6
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          adv_i,
  input  logic          restart_i,
  output logic [NT-1:0] state_o
);

  localparam logic [NT-1:0] FIRST = {{(NT-1){1'b0}}, 1'b1};

  logic [NT-1:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (adv_i) begin
      state_d = restart_i ? FIRST : {state_q[NT-2:0], state_q[NT-1]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state_q <= FIRST;
    else          state_q <= state_d;
  end

  assign state_o = state_q;

endmodule

// File: rtl/sap_ctrl_seq.sv
// SAP-1 control sequencer: decodes T-state, opcode and flags into datapath strobes.
// Define SAP_EARLY_FETCH_EN to end each instruction after its last active T-state.
module sap_ctrl_seq
  import sap_pkg::*;
#(
  parameter int OPW = 4,
  parameter int NT  = 6
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] opcode,
  input  logic           flag_c,
  input  logic           flag_z,
  output logic [NT-1:0]  tstate,
  output logic           pc_oe,
  output logic           pc_inc,
  output logic           pc_load,
  output logic           mar_load,
  output logic           ram_oe,
  output logic           ram_we,
  output logic           ir_load,
  output logic           ir_oe,
  output logic           a_load,
  output logic           a_oe,
  output logic           b_load,
  output logic           alu_oe,
  output logic           alu_sub,
  output logic           flags_load,
  output logic           out_load,
  output logic           halt
);

  logic [NT-1:0] tstate_w;
  opcode_e       op;
  ctrl_word_t    cw;
  logic          halt_q, halt_d;
  logic          set_halt;
  logic          adv;
  logic          restart;

  assign op = opcode_e'(opcode);

  always_comb begin
    cw       = '0;
    set_halt = 1'b0;
    if (tstate_w[T1]) begin
      cw.pc_oe    = 1'b1;
      cw.mar_load = 1'b1;
    end
    if (tstate_w[T2]) cw.pc_inc = 1'b1;
    if (tstate_w[T3]) begin
      cw.ram_oe  = 1'b1;
      cw.ir_load = 1'b1;
    end
    case (op)
      OP_LDA: begin
        if (tstate_w[T4]) begin cw.ir_oe = 1'b1;  cw.mar_load = 1'b1; end
        if (tstate_w[T5]) begin cw.ram_oe = 1'b1; cw.a_load   = 1'b1; end
      end
      OP_ADD, OP_SUB: begin
        if (tstate_w[T4]) begin cw.ir_oe = 1'b1;  cw.mar_load = 1'b1; end
        if (tstate_w[T5]) begin cw.ram_oe = 1'b1; cw.b_load   = 1'b1; end
        if (tstate_w[T6]) begin
          cw.alu_oe     = 1'b1;
          cw.a_load     = 1'b1;
          cw.flags_load = 1'b1;
          cw.alu_sub    = (op == OP_SUB);
        end
      end
      OP_STA: begin
        if (tstate_w[T4]) begin cw.ir_oe = 1'b1; cw.mar_load = 1'b1; end
        if (tstate_w[T5]) begin cw.a_oe = 1'b1;  cw.ram_we   = 1'b1; end
      end
      OP_LDI: if (tstate_w[T4]) begin cw.ir_oe = 1'b1; cw.a_load = 1'b1; end
      OP_JMP: if (tstate_w[T4]) begin cw.ir_oe = 1'b1; cw.pc_load = 1'b1; end
      // Untaken branches leave the bus idle as well as the PC
      OP_JC:  if (tstate_w[T4] && flag_c) begin cw.ir_oe = 1'b1; cw.pc_load = 1'b1; end
      OP_JZ:  if (tstate_w[T4] && flag_z) begin cw.ir_oe = 1'b1; cw.pc_load = 1'b1; end
      OP_OUT: if (tstate_w[T4]) begin cw.a_oe = 1'b1; cw.out_load = 1'b1; end
      OP_HLT: set_halt = tstate_w[T4];
      default: ;
    endcase
    if (!reset || halt_q) begin
      cw       = '0;
      set_halt = 1'b0;
    end
  end

  assign halt_d = halt_q | set_halt;
  // Freeze the ring on the same edge that sets halt, so it parks at T4
  assign adv    = ~halt_d;

  always_ff @(posedge clk) begin
    if (!reset) halt_q <= 1'b0;
    else        halt_q <= halt_d;
  end

`ifdef SAP_EARLY_FETCH_EN
  logic last_step;

  always_comb begin
    last_step = 1'b0;
    case (op)
      OP_LDA, OP_STA:                         last_step = tstate_w[T5];
      OP_ADD, OP_SUB:                         last_step = tstate_w[T6];
      OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT,
      OP_HLT:                                 last_step = tstate_w[T4];
      default:                                last_step = tstate_w[T3];
    endcase
  end

  assign restart = last_step;
`else
  assign restart = 1'b0;
`endif

  sap_ring_counter #(.NT(NT)) u_ring (
    .clk_i     (clk),
    .rst_n_i   (reset),
    .adv_i     (adv),
    .restart_i (restart),
    .state_o   (tstate_w)
  );

  assign tstate     = tstate_w;
  assign pc_oe      = cw.pc_oe;
  assign pc_inc     = cw.pc_inc;
  assign pc_load    = cw.pc_load;
  assign mar_load   = cw.mar_load;
  assign ram_oe     = cw.ram_oe;
  assign ram_we     = cw.ram_we;
  assign ir_load    = cw.ir_load;
  assign ir_oe      = cw.ir_oe;
  assign a_load     = cw.a_load;
  assign a_oe       = cw.a_oe;
  assign b_load     = cw.b_load;
  assign alu_oe     = cw.alu_oe;
  assign alu_sub    = cw.alu_sub;
  assign flags_load = cw.flags_load;
  assign out_load   = cw.out_load;
  assign halt       = halt_q;

endmodule

// File: tb/tb_sap_ctrl_seq.sv
// Directed bench for sap_ctrl_seq: vector table per T-state plus halt, reset and ring-period sequences.
module tb_sap_ctrl_seq;

  localparam logic [14:0] S_PC_OE   = 15'h4000;
  localparam logic [14:0] S_PC_INC  = 15'h2000;
  localparam logic [14:0] S_PC_LOAD = 15'h1000;
  localparam logic [14:0] S_MAR     = 15'h0800;
  localparam logic [14:0] S_RAM_OE  = 15'h0400;
  localparam logic [14:0] S_RAM_WE  = 15'h0200;
  localparam logic [14:0] S_IR_LOAD = 15'h0100;
  localparam logic [14:0] S_IR_OE   = 15'h0080;
  localparam logic [14:0] S_A_LOAD  = 15'h0040;
  localparam logic [14:0] S_A_OE    = 15'h0020;
  localparam logic [14:0] S_B_LOAD  = 15'h0010;
  localparam logic [14:0] S_ALU_OE  = 15'h0008;
  localparam logic [14:0] S_ALU_SUB = 15'h0004;
  localparam logic [14:0] S_FLAGS   = 15'h0002;
  localparam logic [14:0] S_OUT     = 15'h0001;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] opcode = 4'd0;
  logic       flag_c = 1'b0, flag_z = 1'b0;
  logic [5:0] tstate;
  logic pc_oe, pc_inc, pc_load, mar_load, ram_oe, ram_we, ir_load, ir_oe;
  logic a_load, a_oe, b_load, alu_oe, alu_sub, flags_load, out_load, halt;

  int n_run = 0;
  int n_fail = 0;

  sap_ctrl_seq dut (
    .clk(clk), .reset(reset), .opcode(opcode), .flag_c(flag_c), .flag_z(flag_z),
    .tstate(tstate), .pc_oe(pc_oe), .pc_inc(pc_inc), .pc_load(pc_load),
    .mar_load(mar_load), .ram_oe(ram_oe), .ram_we(ram_we), .ir_load(ir_load),
    .ir_oe(ir_oe), .a_load(a_load), .a_oe(a_oe), .b_load(b_load),
    .alu_oe(alu_oe), .alu_sub(alu_sub), .flags_load(flags_load),
    .out_load(out_load), .halt(halt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation time limit reached, n_run=%0d", n_run);
    $fatal(1, "timeout");
  end

  function automatic logic [14:0] strobes();
    return {pc_oe, pc_inc, pc_load, mar_load, ram_oe, ram_we, ir_load, ir_oe,
            a_load, a_oe, b_load, alu_oe, alu_sub, flags_load, out_load};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic        fc;
    logic        fz;
    int          t;
    logic [14:0] exp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    // {op, flag_c, flag_z, T-state (1..6), expected strobes}
    vecs.push_back('{4'd0,  1'b0, 1'b0, 1, S_PC_OE | S_MAR});
    vecs.push_back('{4'd0,  1'b0, 1'b0, 2, S_PC_INC});
    vecs.push_back('{4'd0,  1'b0, 1'b0, 3, S_RAM_OE | S_IR_LOAD});
    vecs.push_back('{4'd1,  1'b0, 1'b0, 4, S_IR_OE | S_MAR});
    vecs.push_back('{4'd1,  1'b0, 1'b0, 5, S_RAM_OE | S_A_LOAD});
    vecs.push_back('{4'd2,  1'b0, 1'b0, 4, S_IR_OE | S_MAR});
    vecs.push_back('{4'd2,  1'b0, 1'b0, 5, S_RAM_OE | S_B_LOAD});
    vecs.push_back('{4'd2,  1'b1, 1'b1, 6, S_ALU_OE | S_A_LOAD | S_FLAGS});
    vecs.push_back('{4'd3,  1'b0, 1'b0, 5, S_RAM_OE | S_B_LOAD});
    vecs.push_back('{4'd3,  1'b0, 1'b0, 6, S_ALU_OE | S_A_LOAD | S_FLAGS | S_ALU_SUB});
    vecs.push_back('{4'd4,  1'b0, 1'b0, 4, S_IR_OE | S_MAR});
    vecs.push_back('{4'd4,  1'b0, 1'b0, 5, S_A_OE | S_RAM_WE});
    vecs.push_back('{4'd5,  1'b0, 1'b0, 4, S_IR_OE | S_A_LOAD});
    vecs.push_back('{4'd6,  1'b0, 1'b0, 4, S_IR_OE | S_PC_LOAD});
    vecs.push_back('{4'd7,  1'b0, 1'b0, 4, 15'h0000});
    vecs.push_back('{4'd7,  1'b1, 1'b0, 4, S_IR_OE | S_PC_LOAD});
    vecs.push_back('{4'd7,  1'b0, 1'b1, 4, 15'h0000});
    vecs.push_back('{4'd8,  1'b1, 1'b0, 4, 15'h0000});
    vecs.push_back('{4'd8,  1'b0, 1'b1, 4, S_IR_OE | S_PC_LOAD});
    vecs.push_back('{4'd14, 1'b0, 1'b0, 4, S_A_OE | S_OUT});
    vecs.push_back('{4'd9,  1'b0, 1'b0, 3, S_RAM_OE | S_IR_LOAD});
`ifndef SAP_EARLY_FETCH_EN
    vecs.push_back('{4'd1,  1'b0, 1'b0, 6, 15'h0000});
    vecs.push_back('{4'd10, 1'b1, 1'b1, 4, 15'h0000});
    vecs.push_back('{4'd5,  1'b0, 1'b0, 5, 15'h0000});
`endif
  end

  initial begin
    logic [14:0] s;
    logic [5:0]  t1_exp;
    int          t1_cycles[$];
    logic        inv_ok;
    string       nm;

    #1;
    // Reset phase: strobes forced low while reset held
    reset = 1'b0;
    opcode = 4'd0;
    #1;
    check("reset_strobes_async", {17'd0, strobes()}, 32'd0);
    step();
    check("reset_hold", {10'd0, tstate, strobes(), halt}, {10'd0, 6'b000001, 15'd0, 1'b0});
    step();
    reset = 1'b1;
    #1;
    check("rel_c0", {10'd0, tstate, strobes()}, {10'd0, 6'b000001, S_PC_OE | S_MAR});
    step();
    check("rel_c1", {10'd0, tstate, strobes()}, {10'd0, 6'b000010, S_PC_INC});
    step();
    check("rel_c2", {10'd0, tstate, strobes()}, {10'd0, 6'b000100, S_RAM_OE | S_IR_LOAD});

    // Vector table
    foreach (vecs[i]) begin
      opcode = vecs[i].op;
      flag_c = vecs[i].fc;
      flag_z = vecs[i].fz;
      do_reset();
      for (int k = 1; k < vecs[i].t; k++) step();
      #1;
      t1_exp = 6'b000001 << (vecs[i].t - 1);
      nm = $sformatf("vec%0d_op%0d_T%0d", i, vecs[i].op, vecs[i].t);
      check(nm, {9'd0, tstate, strobes(), halt, 1'b0}, {9'd0, t1_exp, vecs[i].exp, 1'b0, 1'b0});
    end

    // Invariant sweep over all opcodes and flag combinations
    for (int op = 0; op < 16; op++) begin
      for (int f = 0; f < 4; f++) begin
        opcode = 4'(op);
        flag_c = f[0];
        flag_z = f[1];
        do_reset();
        inv_ok = 1'b1;
        for (int c = 0; c < 8; c++) begin
          #1;
          if (pc_inc && pc_load) inv_ok = 1'b0;
          if ((int'(pc_oe) + int'(ram_oe) + int'(ir_oe) + int'(a_oe) + int'(alu_oe)) > 1) inv_ok = 1'b0;
          if (ram_we && (tstate[0] || tstate[1] || tstate[2])) inv_ok = 1'b0;
          step();
        end
        check($sformatf("invariants_op%0d_f%0d", op, f), {31'd0, inv_ok}, 32'd1);
      end
    end

    // Halt: set on the T4 edge, frozen afterwards, cleared only by reset
    opcode = 4'd15;
    flag_c = 1'b0;
    flag_z = 1'b0;
    do_reset();
    step();
    step();
    step();
    check("hlt_T4", {10'd0, tstate, strobes(), halt}, {10'd0, 6'b001000, 15'd0, 1'b0});
    step();
    check("hlt_set", {10'd0, tstate, strobes(), halt}, {10'd0, 6'b001000, 15'd0, 1'b1});
    inv_ok = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      if (tstate !== 6'b001000 || strobes() !== 15'd0 || halt !== 1'b1) inv_ok = 1'b0;
    end
    check("hlt_frozen_20", {31'd0, inv_ok}, 32'd1);
    reset = 1'b0;
    step();
    reset = 1'b1;
    #1;
    check("hlt_cleared", {10'd0, tstate, strobes(), halt}, {10'd0, 6'b000001, S_PC_OE | S_MAR, 1'b0});

    // LDI back-to-back: T1 period
    opcode = 4'd5;
    do_reset();
    for (int c = 0; c < 14; c++) begin
      #1;
      if (tstate[0]) t1_cycles.push_back(c);
      step();
    end
`ifdef SAP_EARLY_FETCH_EN
    s = 15'd4;
`else
    s = 15'd6;
`endif
    if (t1_cycles.size() >= 3) begin
      check("ldi_period_a", t1_cycles[1] - t1_cycles[0], {17'd0, s});
      check("ldi_period_b", t1_cycles[2] - t1_cycles[1], {17'd0, s});
    end else begin
      check("ldi_t1_count", t1_cycles.size(), 32'd3);
    end

    // Reset during ADD T5: ring back to T1, no T6 strobes
    opcode = 4'd2;
    do_reset();
    for (int c = 0; c < 4; c++) step();
    #1;
    check("add_T5_pre", {10'd0, tstate, strobes()}, {10'd0, 6'b010000, S_RAM_OE | S_B_LOAD});
    reset = 1'b0;
    #1;
    check("add_reset_forced", {17'd0, strobes()}, 32'd0);
    step();
    reset = 1'b1;
    #1;
    check("add_reset_T1", {10'd0, tstate, strobes()}, {10'd0, 6'b000001, S_PC_OE | S_MAR});

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/sap_ctrl_seq.md
Name: sap_ctrl_seq

Overview:
- Control sequencer for the SAP 8-bit CPU: the initiator that drives the program counter's inc/load strobes and every other bus-control line.
- Steps a 6-state T-state ring. Fetch occupies T1–T3; opcode-dependent execute occupies T4–T6.
- Sits between the instruction register (opcode, flags in) and the datapath (pc, MAR, RAM, A, B, ALU, OUT).

Parameters:
- OPW, 4, opcode width (upper IR bits).
- NT, 6, number of T-states in the ring.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-low reset (sampled on rising clk).
- opcode  in  OPW  IR upper bits; valid from T4 onward.
- flag_c  in  1  carry flag from flags register.
- flag_z  in  1  zero flag from flags register.
- tstate  out  NT  one-hot current T-state, bit0 = T1.
- pc_oe, pc_inc, pc_load  out  1 each  PC drive-bus, increment, jump-load.
- mar_load  out  1  MAR capture.
- ram_oe, ram_we  out  1 each  RAM drive-bus, write.
- ir_load, ir_oe  out  1 each  IR capture, IR operand drive-bus.
- a_load, a_oe, b_load  out  1 each  register A/B strobes.
- alu_oe, alu_sub, flags_load  out  1 each  ALU drive, subtract, flags capture.
- out_load  out  1  output register capture.
- halt  out  1  CPU halted, sticky.

Behaviour:
- Reset (reset==0 at a rising edge): tstate=6'b000001, halt=0. While reset is low, all control outputs are forced to 0 combinationally.
- Control outputs are a combinational decode of the registered tstate, opcode, flags and halt. There is no extra latency: a strobe is valid for the whole cycle of its T-state.
- Ring advances one state per clock: T1→T2→…→T6→T1.
- Fetch, identical for all opcodes:
  - T1: pc_oe, mar_load.
  - T2: pc_inc.
  - T3: ram_oe, ir_load.
- Execute (all unlisted T-states assert nothing):
  - 0 NOP: nothing.
  - 1 LDA: T4 ir_oe+mar_load; T5 ram_oe+a_load.
  - 2 ADD: T4 ir_oe+mar_load; T5 ram_oe+b_load; T6 alu_oe+a_load+flags_load.
  - 3 SUB: as ADD, plus alu_sub during T6.
  - 4 STA: T4 ir_oe+mar_load; T5 a_oe+ram_we.
  - 5 LDI: T4 ir_oe+a_load.
  - 6 JMP: T4 ir_oe+pc_load.
  - 7 JC: T4 ir_oe+pc_load only if flag_c==1.
  - 8 JZ: T4 ir_oe+pc_load only if flag_z==1.
  - 14 OUT: T4 a_oe+out_load.
  - 15 HLT: in T4, halt is set at the next edge.
  - Undefined opcodes: NOP.
- Invariants:
  - pc_inc and pc_load are never both 1.
  - At most one *_oe is 1 in any cycle.
  - ram_we is never 1 in T1–T3.
- Halt: once set, tstate freezes and all strobes are 0 (halt stays 1). Only reset clears it.
- Reset mid-instruction: the in-flight instruction is abandoned at the next edge and the ring returns to T1. No partial write-back beyond strobes already issued.

Optional Feature:
- Macro: SAP_EARLY_FETCH_EN.
- Defined: the ring returns to T1 after each opcode's last active step.
  - NOP/undefined: after T3.
  - LDI, JMP, JC, JZ, OUT: after T4.
  - LDA, STA: after T5.
  - ADD, SUB: after T6.
- Not defined: every instruction takes the full 6 T-states.

Decomposition:
- Shared package sap_pkg holds:
  - opcode enum (OP_NOP…OP_HLT).
  - T-state index constants T1..T6.
  - packed ctrl_word_t struct of all strobes; the sequencer builds one ctrl_word_t and drives the ports from it.
- One sub-module, sap_ring_counter: one-hot NT-state ring with sync active-low reset, advance enable, and synchronous restart-to-T1 input.

Test Plan:
- Reset low 2 cycles, then release → cycle0 tstate=000001, pc_oe=mar_load=1; cycle1 pc_inc=1 only; cycle2 ram_oe=ir_load=1; all strobes 0 during reset.
- opcode=6 (JMP) at T4 → ir_oe=pc_load=1, pc_inc=0. Sweep opcodes 0–15 with all flag combinations and check pc_inc&pc_load never 1 and at most one *_oe high.
- opcode=7 (JC): flag_c=0 → T4 pc_load=0; flag_c=1 → T4 pc_load=1. Repeat with opcode=8 and flag_z.
- opcode=2 (ADD) → T5 ram_oe+b_load; T6 alu_oe+a_load+flags_load, alu_sub=0. opcode=3 → same with alu_sub=1 in T6.
- opcode=15 → halt=1 after T4 edge; tstate frozen and all strobes 0 for 20 cycles; reset low 1 cycle → halt=0, tstate=000001.
- LDI repeated: T1 pulses every 4 cycles with SAP_EARLY_FETCH_EN, every 6 without. Reset asserted during ADD T5 → next edge tstate=000001 and no T6 strobes.
